dag_addr_gen: RTL
=================

Name: dag_addr_gen

Overview:
Data address generator for data-memory (DM) accesses.
- Sits downstream of the program sequencer; driven by its ps_dg_* controls.
- Holds 8 index (I), modify (M), length (L) and base (B) registers.
- Produces the registered DM address, with pre-/post-modify and circular-buffer wrap.
- Its registers are universal registers: read and written over the bus-connect path.

Parameters:
DW, 16, data/address width
NIDX, 8, registers per group (I/M/L/B); index width 3 bits

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
ps_dg_en  in  1  address-generation request this cycle (already condition-qualified)
ps_dg_mdfy  in  1  1 = pre-modify, 0 = post-modify
ps_dg_dgsclt  in  1  1 = write back the updated I on post-modify; 0 = address only, no update
ps_dg_iadd  in  3  I/L/B register index for the access
ps_dg_madd  in  3  M register index for the access
ps_dg_wrt_en  in  1  ureg write strobe into the DAG
ps_dg_wrt_add  in  5  ureg write address: [4:3] group (00=I, 01=M, 10=L, 11=B), [2:0] index
ps_dg_rd_add  in  5  ureg read address, same encoding
bc_dt_out  in  DW  write data from bus connect
dg_dm_add  out  DW  DM address, registered
dg_dm_vld  out  1  dg_dm_add valid (registered copy of ps_dg_en)
dg_bc_dt  out  DW  ureg read data to bus connect, combinational
dg_wrap  out  1  pulse: a circular wrap occurred on the last update, registered

Behaviour:
- Reset (async, rst=0): all I/M/L/B = 0; dg_dm_add = 0; dg_dm_vld = 0; dg_wrap = 0. Reset mid-operation aborts any pending update; no write-back happens.
- Arithmetic:
  - All adds are modulo 2^DW.
  - M is two's-complement signed; I, B and L are unsigned.
  - Wrap compares use DW+1-bit unsigned values.
- Pre-modify (ps_dg_en=1, ps_dg_mdfy=1):
  - Next-cycle dg_dm_add = I[iadd] + M[madd].
  - No circular wrap is applied to the address.
  - I is never updated, regardless of dgsclt.
- Post-modify (ps_dg_en=1, ps_dg_mdfy=0):
  - Next-cycle dg_dm_add = I[iadd].
  - nI = I + M computed.
  - If dgsclt=1, I[iadd] <= wrapped nI at the same clock edge.
- Circular wrap (post-modify only), with L = L[iadd] and B = B[iadd]:
  - If L == 0: linear, no wrap, dg_wrap = 0.
  - Else if nI >= B+L: nI - L.
  - Else if nI < B: nI + L.
  - Else: nI unchanged.
  - dg_wrap <= 1 for one cycle when either correction is applied.
  - |M| < L is a programming requirement; the result is undefined otherwise.
- Latency: address = 1 cycle after the request edge; dg_dm_vld high in that same cycle; I update visible to a request issued in the next cycle (back-to-back post-modify on the same I supported).
- Idle (ps_dg_en=0): dg_dm_vld = 0; dg_dm_add holds its last value; dg_wrap = 0.
- Ureg write (ps_dg_wrt_en=1): selected register <= bc_dt_out at clk.
  - A write to B[k] also loads I[k] <= bc_dt_out.
- Collision rules:
  - Ureg write and post-modify write-back target the same I in one cycle: ureg write wins.
  - B[k] write (implicit I[k] load) and post-modify of I[k] in one cycle: ureg path wins.
  - Address generation uses the register contents before the edge; ureg write data is not forwarded into the address path.
- Ureg read: dg_bc_dt = selected register (combinational).
  - Bypass: if ps_dg_wrt_en=1 and ps_dg_wrt_add == ps_dg_rd_add, dg_bc_dt = bc_dt_out.
  - Reading I[k] in the cycle of its post-modify update returns the old value.

Decomposition:
- Shared package (dag_pkg): group codes DG_GRP_I/M/L/B (2'b00..11), DW, NIDX, and a 5-bit ureg address field split (group, index).
- One natural sub-module, dag_circ_upd: combinational I+M with B/L wrap. Inputs I, M, B, L; outputs nI and wrap flag.
- Register files and read/bypass mux stay in the top.

Test Plan:
1. Reset then read all 32 ureg addresses -> all 0; dg_dm_vld = 0; dg_wrap = 0.
2. Write B0=0x0100 (I0 becomes 0x0100), L0=4, M0=1; four post-modify requests (dgsclt=1) -> dg_dm_add = 0x0100, 0x0101, 0x0102, 0x0103, then I0 = 0x0100; dg_wrap = 1 only after the 4th update.
3. M1 = 0xFFFE (-2), I2 = 0x0010, L2 = 0; post-modify -> address 0x0010, I2 = 0x000E; repeat from I2 = 0x0001 -> I2 = 0xFFFF (linear modulo wrap, no dg_wrap).
4. Pre-modify with I3 = 0x0200, M3 = 5 -> dg_dm_add = 0x0205 one cycle later; I3 still 0x0200.
5. Same cycle: ureg write I0 = 0x0555 plus post-modify of I0 -> I0 = 0x0555; same-cycle read of wrt_add returns bc_dt_out (bypass).
6. Assert rst during a back-to-back post-modify stream -> outputs and registers 0 immediately; no late write-back after rst deasserts.

Source files
------------

// File: rtl/dag_pkg.sv
// Shared definitions for the data address generator: widths, ureg group codes
// and the 5-bit ureg address layout.
package dag_pkg;

  localparam int DW   = 16;
  localparam int NIDX = 8;

  typedef enum logic [1:0] {
    DG_GRP_I = 2'b00,
    DG_GRP_M = 2'b01,
    DG_GRP_L = 2'b10,
    DG_GRP_B = 2'b11
  } dg_grp_t;

  typedef struct packed {
    dg_grp_t    grp;
    logic [2:0] idx;
  } ureg_addr_t;

  function automatic ureg_addr_t split_ureg_addr(input logic [4:0] add);
    return ureg_addr_t'(add);
  endfunction

endpackage

// File: rtl/dag_circ_upd.sv
// Combinational index update: nI = I + M with optional circular-buffer wrap
// into the window [B, B+L).
module dag_circ_upd #(
  parameter int DW = 16
) (
  input  logic [DW-1:0] i_val,
  input  logic [DW-1:0] m_val,
  input  logic [DW-1:0] b_val,
  input  logic [DW-1:0] l_val,
  output logic [DW-1:0] ni_val,
  output logic          wrap
);

  logic [DW-1:0] sum;
  logic [DW:0]   limit;

  always_comb begin
    sum    = i_val + m_val;
    // Window end needs the extra bit: B+L may exceed 2^DW.
    limit  = {1'b0, b_val} + {1'b0, l_val};
    ni_val = sum;
    wrap   = 1'b0;
    if (l_val != '0) begin
      if ({1'b0, sum} >= limit) begin
        ni_val = sum - l_val;
        wrap   = 1'b1;
      end else if (sum < b_val) begin
        ni_val = sum + l_val;
        wrap   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dag_addr_gen.sv
// Data address generator: I/M/L/B register files, registered DM address with
// pre-/post-modify and circular wrap, and universal-register read/write access.
module dag_addr_gen #(
  parameter int DW   = 16,
  parameter int NIDX = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ps_dg_en,
  input  logic          ps_dg_mdfy,
  input  logic          ps_dg_dgsclt,
  input  logic [2:0]    ps_dg_iadd,
  input  logic [2:0]    ps_dg_madd,
  input  logic          ps_dg_wrt_en,
  input  logic [4:0]    ps_dg_wrt_add,
  input  logic [4:0]    ps_dg_rd_add,
  input  logic [DW-1:0] bc_dt_out,
  output logic [DW-1:0] dg_dm_add,
  output logic          dg_dm_vld,
  output logic [DW-1:0] dg_bc_dt,
  output logic          dg_wrap
);

  import dag_pkg::*;

  logic [DW-1:0] ireg [NIDX];
  logic [DW-1:0] mreg [NIDX];
  logic [DW-1:0] lreg [NIDX];
  logic [DW-1:0] breg [NIDX];

  logic [DW-1:0] cur_i, cur_m, next_i;
  logic          circ_wrap, write_back;
  ureg_addr_t    wa, ra;

  assign cur_i      = ireg[ps_dg_iadd];
  assign cur_m      = mreg[ps_dg_madd];
  assign write_back = ps_dg_en & ~ps_dg_mdfy & ps_dg_dgsclt;
  assign wa         = split_ureg_addr(ps_dg_wrt_add);
  assign ra         = split_ureg_addr(ps_dg_rd_add);

  dag_circ_upd #(.DW(DW)) u_circ (
    .i_val  (cur_i),
    .m_val  (cur_m),
    .b_val  (breg[ps_dg_iadd]),
    .l_val  (lreg[ps_dg_iadd]),
    .ni_val (next_i),
    .wrap   (circ_wrap)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dg_dm_add <= '0;
      dg_dm_vld <= 1'b0;
      dg_wrap   <= 1'b0;
      for (int unsigned k = 0; k < NIDX; k++) begin
        ireg[k] <= '0;
        mreg[k] <= '0;
        lreg[k] <= '0;
        breg[k] <= '0;
      end
    end else begin
      dg_dm_vld <= ps_dg_en;
      dg_wrap   <= write_back & circ_wrap;
      if (ps_dg_en)
        dg_dm_add <= ps_dg_mdfy ? (cur_i + cur_m) : cur_i;
      if (write_back)
        ireg[ps_dg_iadd] <= next_i;
      // Ureg writes come last so they override a same-cycle write-back.
      if (ps_dg_wrt_en) begin
        unique case (wa.grp)
          DG_GRP_I: ireg[wa.idx] <= bc_dt_out;
          DG_GRP_M: mreg[wa.idx] <= bc_dt_out;
          DG_GRP_L: lreg[wa.idx] <= bc_dt_out;
          DG_GRP_B: begin
            breg[wa.idx] <= bc_dt_out;
            ireg[wa.idx] <= bc_dt_out;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    dg_bc_dt = '0;
    if (ps_dg_wrt_en && (ps_dg_wrt_add == ps_dg_rd_add)) begin
      dg_bc_dt = bc_dt_out;
    end else begin
      unique case (ra.grp)
        DG_GRP_I: dg_bc_dt = ireg[ra.idx];
        DG_GRP_M: dg_bc_dt = mreg[ra.idx];
        DG_GRP_L: dg_bc_dt = lreg[ra.idx];
        DG_GRP_B: dg_bc_dt = breg[ra.idx];
        default:  dg_bc_dt = '0;
      endcase
    end
  end

endmodule
